// File: rtl/mem_stage.sv
// mem_stage
//   Pipeline memory-access stage. Pass ops flow through combinationally.
//   Loads and stores become a sequence of single-byte transfers over a
//   byte-wide memory port, little-endian and without any alignment
//   restriction, with the pipeline stalled until the access completes.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   wd_i/wreg_i    destination register / write enable from EX/MEM
//   wdata_i        ALU result, or the effective address for loads/stores
//   mmem_data_i    store data
//   op_type_i      0 pass, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW,
//                  anything else pass
//   mem_req_o      byte request valid
//   mem_we_o       byte request is a write
//   mem_addr_o     byte address
//   mem_wdata_o    byte write data
//   mem_ready_i    controller accepts the request (sampled only while mem_req_o=1)
//   mem_rdata_i    returned read byte
//   mem_rvalid_i   mem_rdata_i valid (ignored outside the wait-for-data phase)
//   wd_o/wreg_o/wdata_o  to MEM/WB register
//   stallreq_o     holds the pipeline while an access is in progress
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mmem_data_i,
  input  logic [3:0]  op_type_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [1:0]  idx;
  logic [31:0] base;
  logic [31:0] buffer;
  logic [3:0]  op_q;

  logic        op_store;
  logic [1:0]  last_idx;
  logic        last_byte;
  logic        new_mem_op;
  logic [31:0] load_result;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  // Index of the final byte of the access: N-1 for N = 1, 2 or 4.
  function automatic logic [1:0] last_of(input logic [3:0] op);
    logic [1:0] r;
    case (op)
      4'd1, 4'd4, 4'd6: r = 2'd0;
      4'd2, 4'd5, 4'd7: r = 2'd1;
      default:          r = 2'd3;
    endcase
    return r;
  endfunction

  assign new_mem_op = is_load(op_type_i) || is_store(op_type_i);
  assign op_store   = is_store(op_q);
  assign last_idx   = last_of(op_q);
  assign last_byte  = (idx == last_idx);

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (new_mem_op) state_n = S_REQ;
      S_REQ: begin
        if (mem_ready_i) begin
          if (op_store) state_n = last_byte ? S_DONE : S_REQ;
          else          state_n = S_WAIT;
        end
      end
      S_WAIT: if (mem_rvalid_i) state_n = last_byte ? S_DONE : S_REQ;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      base   <= '0;
      buffer <= '0;
      op_q   <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (new_mem_op) begin
            idx    <= '0;
            base   <= wdata_i;
            op_q   <= op_type_i;
            buffer <= '0;
          end
        end
        S_REQ: begin
          // Loads advance idx when their byte returns, stores on accept.
          if (mem_ready_i && op_store) idx <= idx + 2'd1;
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            buffer[{idx, 3'b000} +: 8] <= mem_rdata_i;
            idx                        <= idx + 2'd1;
          end
        end
        S_DONE: idx <= '0;
        default: idx <= '0;
      endcase
    end
  end

  // Width/sign extension of the assembled load data
  always_comb begin
    case (op_q)
      4'd1:    load_result = {{24{buffer[7]}}, buffer[7:0]};
      4'd2:    load_result = {{16{buffer[15]}}, buffer[15:0]};
      4'd4:    load_result = {24'h0, buffer[7:0]};
      4'd5:    load_result = {16'h0, buffer[15:0]};
      default: load_result = buffer;
    endcase
  end

  // Outputs. Everything is forced to zero while rst is low, including the
  // combinational pass-through path.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stallreq_o  = 1'b0;
    if (rst) begin
      case (state)
        S_IDLE: begin
          wd_o = wd_i;
          if (new_mem_op) begin
            stallreq_o = 1'b1;
          end else begin
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        S_REQ: begin
          wd_o        = wd_i;
          stallreq_o  = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = op_store;
          mem_addr_o  = base + {30'h0, idx};
          mem_wdata_o = mmem_data_i[{idx, 3'b000} +: 8];
        end
        S_WAIT: begin
          wd_o       = wd_i;
          stallreq_o = 1'b1;
        end
        S_DONE: begin
          wd_o = wd_i;
          if (!op_store) begin
            wreg_o  = wreg_i;
            wdata_o = load_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Directed scenarios with literal expectations, then randomized traffic
//   from a pipeline-like driver and a byte-memory responder. A transaction
//   level model (byte list per op, extension rules applied arithmetically)
//   checks the DUT outputs on every cycle.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mmem_data_i;
  logic [3:0]  op_type_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_ready_i;
  logic [7:0]  mem_rdata_i;
  logic        mem_rvalid_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .mmem_data_i  (mmem_data_i),
    .op_type_i    (op_type_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_mem(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic int m_nbytes(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 1;
    if (op == 4'd2 || op == 4'd5 || op == 4'd7) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_extend(input logic [3:0] op, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd1:    r = b[7]  ? 32'(b[7:0])  - 32'd256     : 32'(b[7:0]);
      4'd2:    r = b[15] ? 32'(b[15:0]) - 32'h10000   : 32'(b[15:0]);
      4'd4:    r = b & 32'h0000_00FF;
      4'd5:    r = b & 32'h0000_FFFF;
      default: r = b;
    endcase
    return r;
  endfunction

  bit          m_active = 0;
  bit          m_wait   = 0;
  bit          m_finish = 0;
  bit          m_store  = 0;
  int          m_k      = 0;
  int          m_n      = 0;
  logic [31:0] m_base;
  logic [31:0] m_data;
  logic [31:0] m_buf;
  logic [3:0]  m_op;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_stall", stallreq_o, 0);
      chk("rst_wd", wd_o, 0);
      chk("rst_wreg", wreg_o, 0);
      chk("rst_wdata", wdata_o, 0);
      chk("rst_req", mem_req_o, 0);
      chk("rst_we", mem_we_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_bwdata", mem_wdata_o, 0);
      m_active = 0;
      m_wait   = 0;
      m_finish = 0;
    end else if (m_finish) begin
      chk("done_stall", stallreq_o, 0);
      chk("done_req", mem_req_o, 0);
      chk("done_wd", wd_o, wd_i);
      chk("done_wreg", wreg_o, m_store ? 1'b0 : wreg_i);
      chk("done_wdata", wdata_o, m_store ? 32'h0 : m_extend(m_op, m_buf));
      m_finish = 0;
      m_active = 0;
    end else if (m_active) begin
      chk("busy_stall", stallreq_o, 1);
      chk("busy_wreg", wreg_o, 0);
      chk("busy_wdata", wdata_o, 0);
      if (m_wait) begin
        chk("wait_req", mem_req_o, 0);
        if (mem_rvalid_i) begin
          m_buf[8*m_k +: 8] = mem_rdata_i;
          m_k++;
          m_wait = 0;
          if (m_k == m_n) m_finish = 1;
        end
      end else begin
        chk("req_req", mem_req_o, 1);
        chk("req_addr", mem_addr_o, m_base + 32'(m_k));
        chk("req_we", mem_we_o, m_store);
        if (m_store) chk("req_byte", mem_wdata_o, m_data[8*m_k +: 8]);
        if (mem_ready_i) begin
          if (m_store) begin
            m_k++;
            if (m_k == m_n) m_finish = 1;
          end else begin
            m_wait = 1;
          end
        end
      end
    end else if (m_is_mem(op_type_i)) begin
      chk("start_stall", stallreq_o, 1);
      chk("start_wreg", wreg_o, 0);
      chk("start_req", mem_req_o, 0);
      m_active = 1;
      m_wait   = 0;
      m_k      = 0;
      m_n      = m_nbytes(op_type_i);
      m_op     = op_type_i;
      m_store  = (op_type_i >= 4'd6);
      m_base   = wdata_i;
      m_data   = mmem_data_i;
      m_buf    = '0;
    end else begin
      chk("pass_wd", wd_o, wd_i);
      chk("pass_wreg", wreg_o, wreg_i);
      chk("pass_wdata", wdata_o, wdata_i);
      chk("pass_stall", stallreq_o, 0);
      chk("pass_req", mem_req_o, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] wd, input logic wr);
    op_type_i   = op;
    wdata_i     = a;
    mmem_data_i = d;
    wd_i        = wd;
    wreg_i      = wr;
  endtask

  logic [31:0] seen_addr [4];
  logic [31:0] ld_result;

  // Load with ready=1 and each byte returned in the cycle after its accept.
  task automatic load_seq(input logic [3:0] op, input logic [31:0] a,
                          input int n, input logic [31:0] rb);
    nxt();
    set_op(op, a, 32'h0, 5'd9, 1'b1);
    mem_ready_i  = 1'b1;
    mem_rvalid_i = 1'b0;
    smp();
    chk("ld_idle_stall", stallreq_o, 1);
    for (int k = 0; k < n; k++) begin
      nxt();
      mem_rvalid_i = 1'b0;
      smp();
      chk("ld_req", mem_req_o, 1);
      seen_addr[k] = mem_addr_o;
      nxt();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rb[8*k +: 8];
      smp();
      chk("ld_wait_stall", stallreq_o, 1);
    end
    nxt();
    mem_rvalid_i = 1'b0;
    smp();
    chk("ld_done_stall", stallreq_o, 0);
    chk("ld_done_wreg", wreg_o, 1);
    ld_result = wdata_o;
  endtask

  logic [31:0] sw_data;
  logic [31:0] sh_data;
  bit          acc_rd;
  bit          stall_now;
  bit          rd_out;
  int          rd_dly;

  initial begin
    rst          = 1'b0;
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 8'h00;
    set_op(4'd0, 32'h1234, 32'h0, 5'd5, 1'b1);

    // reset forces outputs low even with live pass inputs
    smp();
    chk("lit_rst_wd", wd_o, 0);
    chk("lit_rst_wreg", wreg_o, 0);
    chk("lit_rst_wdata", wdata_o, 0);

    // pass-through
    nxt();
    rst = 1'b1;
    smp();
    chk("lit_pass_wd", wd_o, 5'd5);
    chk("lit_pass_wreg", wreg_o, 1);
    chk("lit_pass_wdata", wdata_o, 32'h1234);
    chk("lit_pass_stall", stallreq_o, 0);

    // SW 0x100 <- AABBCCDD, ready always high
    sw_data = 32'hAABBCCDD;
    nxt();
    set_op(4'd8, 32'h100, sw_data, 5'd3, 1'b1);
    mem_ready_i = 1'b1;
    smp();
    chk("lit_sw_idle_stall", stallreq_o, 1);
    for (int k = 0; k < 4; k++) begin
      nxt();
      smp();
      chk("lit_sw_addr", mem_addr_o, 32'h100 + 32'(k));
      chk("lit_sw_byte", mem_wdata_o, sw_data[8*k +: 8]);
      chk("lit_sw_we", mem_we_o, 1);
      chk("lit_sw_stall", stallreq_o, 1);
    end
    nxt();
    smp();
    chk("lit_sw_done_stall", stallreq_o, 0);
    chk("lit_sw_done_wreg", wreg_o, 0);

    // LB / LBU of 0x80 at address 7, back to back
    load_seq(4'd1, 32'h7, 1, 32'h80);
    chk("lit_lb_result", ld_result, 32'hFFFFFF80);
    chk("lit_lb_addr", seen_addr[0], 32'h7);
    load_seq(4'd4, 32'h7, 1, 32'h80);
    chk("lit_lbu_result", ld_result, 32'h00000080);

    // SH with ready low for three cycles on byte 0
    sh_data = 32'h1234BEEF;
    nxt();
    set_op(4'd7, 32'h20, sh_data, 5'd4, 1'b1);
    mem_ready_i = 1'b0;
    smp();
    chk("lit_sh_idle_stall", stallreq_o, 1);
    for (int r = 0; r < 3; r++) begin
      nxt();
      smp();
      chk("lit_sh_hold_addr", mem_addr_o, 32'h20);
      chk("lit_sh_hold_byte", mem_wdata_o, 8'hEF);
      chk("lit_sh_hold_we", mem_we_o, 1);
      chk("lit_sh_hold_stall", stallreq_o, 1);
    end
    nxt();
    mem_ready_i = 1'b1;
    smp();
    chk("lit_sh_b0_addr", mem_addr_o, 32'h20);
    nxt();
    smp();
    chk("lit_sh_b1_addr", mem_addr_o, 32'h21);
    chk("lit_sh_b1_byte", mem_wdata_o, 8'hBE);
    nxt();
    smp();
    chk("lit_sh_done_stall", stallreq_o, 0);
    chk("lit_sh_done_wreg", wreg_o, 0);

    // reset while a LW waits for data; stale rvalid after release
    nxt();
    set_op(4'd3, 32'h40, 32'h0, 5'd6, 1'b1);
    smp();
    nxt();
    smp();
    nxt();
    smp();
    chk("lit_rst_wait_req", mem_req_o, 0);
    chk("lit_rst_wait_stall", stallreq_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("lit_rst_now_stall", stallreq_o, 0);
    chk("lit_rst_now_req", mem_req_o, 0);
    chk("lit_rst_now_wdata", wdata_o, 0);
    chk("lit_rst_now_wd", wd_o, 0);
    nxt();
    nxt();
    rst = 1'b1;
    set_op(4'd0, 32'h55, 32'h0, 5'd7, 1'b1);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 8'hEE;
    smp();
    chk("lit_stale_wd", wd_o, 5'd7);
    chk("lit_stale_wdata", wdata_o, 32'h55);
    chk("lit_stale_stall", stallreq_o, 0);
    load_seq(4'd4, 32'h3, 1, 32'h7F);
    chk("lit_after_rst_lbu", ld_result, 32'h0000007F);

    // LW across the top of the address space
    load_seq(4'd3, 32'hFFFFFFFE, 4, 32'h44332211);
    chk("lit_lw_result", ld_result, 32'h44332211);
    chk("lit_lw_a0", seen_addr[0], 32'hFFFFFFFE);
    chk("lit_lw_a1", seen_addr[1], 32'hFFFFFFFF);
    chk("lit_lw_a2", seen_addr[2], 32'h00000000);
    chk("lit_lw_a3", seen_addr[3], 32'h00000001);

    // ---------------- randomized traffic ----------------
    nxt();
    set_op(4'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    rd_out = 0;
    rd_dly = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      smp();
      acc_rd    = rst && mem_req_o && mem_ready_i && !mem_we_o;
      stall_now = stallreq_o;
      nxt();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst = 1'b0;
      if (acc_rd) begin
        rd_out = 1;
        rd_dly = $urandom_range(0, 2);
      end
      mem_rdata_i = 8'($urandom);
      if (rd_out && rd_dly == 0) begin
        mem_rvalid_i = 1'b1;
        rd_out       = 0;
      end else if (rd_out) begin
        mem_rvalid_i = 1'b0;
        rd_dly--;
      end else begin
        // spurious returns while nothing is outstanding must be ignored
        mem_rvalid_i = ($urandom_range(0, 9) == 0);
      end
      mem_ready_i = ($urandom_range(0, 3) != 0);
      if (!stall_now) begin
        set_op(($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom,
               $urandom, 5'($urandom), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
